pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RV32 pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable/flush from three sources:
  - load-use hazards;
  - EX-stage control-flow redirects;
  - variable-latency data-memory handshakes, with a wait-timeout watchdog.
- Keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 256, max consecutive MEM_WAIT cycles before error (≥2)
- CNT_W, 32, width of performance counters

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset
- ID_i_rs1_addr  in  5  rs1 of instruction in ID
- ID_i_rs2_addr  in  5  rs2 of instruction in ID
- ID_i_rs1_used  in  1  ID instruction reads rs1
- ID_i_rs2_used  in  1  ID instruction reads rs2
- EX_i_rd_addr  in  5  rd of instruction in EX
- EX_i_is_load  in  1  EX instruction is a load (wb_sel = memory)
- EX_i_redirect  in  1  EX resolved taken branch/jump (PC must be redirected)
- MEM_i_mem_req  in  1  instruction in MEM accesses data memory
- MEM_i_mem_ack  in  1  data memory completes the access this cycle
- o_pc_en  out  1  PC update enable
- IF_ID_o_en, ID_EX_o_en, EX_MEM_o_en, MEM_WB_o_en  out  1 each  stage register load enable
- IF_ID_o_flush, ID_EX_o_flush, EX_MEM_o_flush, MEM_WB_o_flush  out  1 each  load bubble (all-zero) instead of input
- o_err  out  1  sticky memory-timeout error
- o_stall_cycles  out  CNT_W  cycles with o_pc_en=0 in RUN/MEM_WAIT
- o_flush_count  out  CNT_W  applied redirect events

Behaviour:
Reset and flush rules:
- Reset is i_reset_n, asynchronous, active-low; clock is i_clk.
- While reset is asserted: state=INIT, counters=0, o_err=0; all *_en=0, all *_flush=1, o_pc_en=0.
- Flush takes priority over en at the stage register: flush=1 loads a bubble when en=1.
- Outputs are combinational from registered state plus current inputs, giving same-cycle stall.

FSM states INIT, RUN, MEM_WAIT, ERR:
- INIT (first cycle after reset release):
  - all en=1, all flush=1, o_pc_en=0.
  - Next state RUN.
- RUN, evaluated in priority order:
  1. Memory stall, when MEM_i_mem_req=1 and MEM_i_mem_ack=0:
     - o_pc_en, IF_ID_en, ID_EX_en, EX_MEM_en = 0.
     - MEM_WB_en=1, MEM_WB_flush=1.
     - Wait counter loads 1. Next state MEM_WAIT.
     - Redirect and load-use are ignored this cycle.
     - Req with ack in the same cycle is a zero-wait access: no stall.
  2. Redirect (EX_i_redirect=1):
     - o_pc_en=1, all en=1.
     - IF_ID_flush=1, ID_EX_flush=1.
     - o_flush_count increments.
     - Overrides load-use.
  3. Load-use, when EX_i_is_load=1, EX_i_rd_addr≠0, and (rs1_used and rs1==rd) or (rs2_used and rs2==rd):
     - o_pc_en=0, IF_ID_en=0.
     - ID_EX_en=1, ID_EX_flush=1.
     - EX_MEM and MEM_WB enabled.
     - Exactly one bubble per hazard.
  4. Otherwise: all en=1, all flush=0, o_pc_en=1.
- MEM_WAIT:
  - If MEM_i_mem_ack=0, outputs are as in the memory-stall case and the wait counter increments.
    - If the counter reaches MEM_TIMEOUT, next state is ERR.
  - If MEM_i_mem_ack=1, the frozen stages release, and redirect and load-use are evaluated as in RUN priority 2–4. Next state RUN.
    - A redirect held during the stall is applied on this cycle; the frozen ID/EX keeps EX_i_redirect asserted.
- ERR:
  - all en=0, all flush=0, o_pc_en=0, o_err=1.
  - Left only by reset.
  - Counters freeze.

Counters:
- o_stall_cycles increments on every RUN/MEM_WAIT cycle with o_pc_en=0.
- Both counters saturate at all-ones.
- Not counted in INIT or ERR.
- Counters and wait counter reset asynchronously to 0.

Reset asserted mid-stall: immediate return to the reset output values above; no pending redirect is retained.

Test Plan:
- Reset release -> exactly one INIT cycle with all flush=1, o_pc_en=0. Then RUN with all en=1, flush=0, counters 0.
- Load in EX, rd=5; ID rs2=5, rs2_used=1 -> one cycle o_pc_en=0, IF_ID_en=0, ID_EX_flush=1. Next cycle normal. o_stall_cycles=1. Repeat with rd=0 -> no stall.
- Same cycle redirect and load-use hazard -> o_pc_en=1, IF_ID_flush=ID_EX_flush=1, no stall. o_flush_count=1.
- mem_req=1 with ack after 3 wait cycles; redirect asserted throughout -> 3 frozen cycles with MEM_WB_flush=1. Redirect applied on the ack cycle. o_stall_cycles=3, o_flush_count=1.
- mem_req=1 with ack the same cycle -> zero stall cycles, state stays RUN.
- MEM_TIMEOUT=4, ack never arrives -> ERR entered after 4 wait cycles. o_err=1 sticky, all en=0. Clears only on i_reset_n=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/stall sequencer.
// The datapath (master) reports hazard sources; the sequencer (slave) returns enables and flushes.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_i_rs1_addr;
    logic [4:0]       ID_i_rs2_addr;
    logic             ID_i_rs1_used;
    logic             ID_i_rs2_used;
    logic [4:0]       EX_i_rd_addr;
    logic             EX_i_is_load;
    logic             EX_i_redirect;
    logic             MEM_i_mem_req;
    logic             MEM_i_mem_ack;

    logic             o_pc_en;
    logic             IF_ID_o_en;
    logic             ID_EX_o_en;
    logic             EX_MEM_o_en;
    logic             MEM_WB_o_en;
    logic             IF_ID_o_flush;
    logic             ID_EX_o_flush;
    logic             EX_MEM_o_flush;
    logic             MEM_WB_o_flush;
    logic             o_err;
    logic [CNT_W-1:0] o_stall_cycles;
    logic [CNT_W-1:0] o_flush_count;

    modport master (
        output ID_i_rs1_addr, ID_i_rs2_addr, ID_i_rs1_used, ID_i_rs2_used,
        output EX_i_rd_addr, EX_i_is_load, EX_i_redirect,
        output MEM_i_mem_req, MEM_i_mem_ack,
        input  o_pc_en, IF_ID_o_en, ID_EX_o_en, EX_MEM_o_en, MEM_WB_o_en,
        input  IF_ID_o_flush, ID_EX_o_flush, EX_MEM_o_flush, MEM_WB_o_flush,
        input  o_err, o_stall_cycles, o_flush_count
    );

    modport slave (
        input  ID_i_rs1_addr, ID_i_rs2_addr, ID_i_rs1_used, ID_i_rs2_used,
        input  EX_i_rd_addr, EX_i_is_load, EX_i_redirect,
        input  MEM_i_mem_req, MEM_i_mem_ack,
        output o_pc_en, IF_ID_o_en, ID_EX_o_en, EX_MEM_o_en, MEM_WB_o_en,
        output IF_ID_o_flush, ID_EX_o_flush, EX_MEM_o_flush, MEM_WB_o_flush,
        output o_err, o_stall_cycles, o_flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for a 5-stage RV32 core: per-stage enable/flush from load-use,
// EX redirects and data-memory wait states, with a wait watchdog and perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERR} state_t;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              active, load_use, mem_hold;
    logic              stall_evt, redirect_applied;
    logic              pc_en, err;
    // Bit order for en/flush: [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB
    logic [3:0]        en, flush;

    assign active   = (state == RUN) || (state == MEM_WAIT);
    assign load_use = bus.EX_i_is_load && (bus.EX_i_rd_addr != 5'd0) &&
                      ((bus.ID_i_rs1_used && (bus.ID_i_rs1_addr == bus.EX_i_rd_addr)) ||
                       (bus.ID_i_rs2_used && (bus.ID_i_rs2_addr == bus.EX_i_rd_addr)));
    // A request acked in the same cycle is a zero-wait access and never holds the pipe.
    assign mem_hold = (state == RUN)      ? (bus.MEM_i_mem_req && !bus.MEM_i_mem_ack) :
                      (state == MEM_WAIT) ? !bus.MEM_i_mem_ack : 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= INIT;
        else            state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        state_next = state;
        case (state)
            INIT:     state_next = RUN;
            RUN:      if (mem_hold) state_next = MEM_WAIT;
            MEM_WAIT: begin
                if (bus.MEM_i_mem_ack)        state_next = RUN;
                else if (wait_cnt == WAIT_LAST) state_next = ERR;
            end
            ERR:      state_next = ERR;
            default:  state_next = INIT;
        endcase
    end

    always_comb begin
        pc_en = 1'b0;
        en    = 4'b0000;
        flush = 4'b0000;
        err   = 1'b0;
        if (!i_reset_n) begin
            flush = 4'b1111;
        end else begin
            case (state)
                INIT: begin
                    en    = 4'b1111;
                    flush = 4'b1111;
                end
                RUN, MEM_WAIT: begin
                    if (mem_hold) begin
                        en    = 4'b0001;
                        flush = 4'b0001;
                    end else if (bus.EX_i_redirect) begin
                        pc_en = 1'b1;
                        en    = 4'b1111;
                        flush = 4'b1100;
                    end else if (load_use) begin
                        en    = 4'b0111;
                        flush = 4'b0100;
                    end else begin
                        pc_en = 1'b1;
                        en    = 4'b1111;
                    end
                end
                ERR:     err = 1'b1;
                default: ;
            endcase
        end
    end

    assign stall_evt        = active && !pc_en;
    assign redirect_applied = active && !mem_hold && bus.EX_i_redirect;

    // NOTE: the wait and perf counters are plain registers, so they take the asynchronous reset too.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt <= '0;
        end else if (mem_hold) begin
            wait_cnt <= (state == RUN) ? WAIT_W'(1) : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != CNT_MAX))        stall_cnt <= stall_cnt + 1'b1;
            if (redirect_applied && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.o_pc_en        = pc_en;
    assign bus.IF_ID_o_en     = en[3];
    assign bus.ID_EX_o_en     = en[2];
    assign bus.EX_MEM_o_en    = en[1];
    assign bus.MEM_WB_o_en    = en[0];
    assign bus.IF_ID_o_flush  = flush[3];
    assign bus.ID_EX_o_flush  = flush[2];
    assign bus.EX_MEM_o_flush = flush[1];
    assign bus.MEM_WB_o_flush = flush[0];
    assign bus.o_err          = err;
    assign bus.o_stall_cycles = stall_cnt;
    assign bus.o_flush_count  = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table pushed through a scoreboard queue, plus
// hand-written reset, mid-stall reset and counter saturation sequences.
module tb_pipe_hazard_ctrl;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Control word: {pc_en, en[IF_ID,ID_EX,EX_MEM,MEM_WB], flush[same order], err}
    localparam logic [9:0] C_RESET  = {1'b0, 4'b0000, 4'b1111, 1'b0};
    localparam logic [9:0] C_INIT   = {1'b0, 4'b1111, 4'b1111, 1'b0};
    localparam logic [9:0] C_NORMAL = {1'b1, 4'b1111, 4'b0000, 1'b0};
    localparam logic [9:0] C_MEMSTL = {1'b0, 4'b0001, 4'b0001, 1'b0};
    localparam logic [9:0] C_REDIR  = {1'b1, 4'b1111, 4'b1100, 1'b0};
    localparam logic [9:0] C_LDUSE  = {1'b0, 4'b0111, 4'b0100, 1'b0};
    localparam logic [9:0] C_ERR    = {1'b0, 4'b0000, 4'b0000, 1'b1};

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       rs1_used, rs2_used, is_load, redirect, req, ack;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_stall, exp_flush;
    logic [9:0] sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    function automatic vec_t mk(string n, int rs1, int u1, int rs2, int u2, int rd,
                                int ld, int rdr, int req, int ack, logic [9:0] exp);
        vec_t v;
        v.name = n;       v.rs1 = 5'(rs1);     v.rs1_used = (u1 != 0);
        v.rs2 = 5'(rs2);  v.rs2_used = (u2 != 0); v.rd = 5'(rd);
        v.is_load = (ld != 0); v.redirect = (rdr != 0);
        v.req = (req != 0);    v.ack = (ack != 0);  v.exp = exp;
        return v;
    endfunction

    function automatic logic [9:0] ctl_now();
        return {bus.o_pc_en, bus.IF_ID_o_en, bus.ID_EX_o_en, bus.EX_MEM_o_en, bus.MEM_WB_o_en,
                bus.IF_ID_o_flush, bus.ID_EX_o_flush, bus.EX_MEM_o_flush, bus.MEM_WB_o_flush,
                bus.o_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        bus.ID_i_rs1_addr = v.rs1;
        bus.ID_i_rs2_addr = v.rs2;
        bus.ID_i_rs1_used = v.rs1_used;
        bus.ID_i_rs2_used = v.rs2_used;
        bus.EX_i_rd_addr  = v.rd;
        bus.EX_i_is_load  = v.is_load;
        bus.EX_i_redirect = v.redirect;
        bus.MEM_i_mem_req = v.req;
        bus.MEM_i_mem_ack = v.ack;
    endtask

    // One cycle: drive after the edge, compare at the falling edge, then step the model.
    task automatic apply(input vec_t v);
        logic [9:0] exp;
        drive(v);
        sb_q.push_back(v.exp);
        @(negedge clk);
        exp = sb_q.pop_front();
        check({v.name, " ctl"}, 32'(ctl_now()), 32'(exp));
        check({v.name, " stall_cycles"}, 32'(bus.o_stall_cycles), 32'(exp_stall));
        check({v.name, " flush_count"}, 32'(bus.o_flush_count), 32'(exp_flush));
        if (!exp[9] && !exp[0] && exp_stall < CNT_MAX) exp_stall++;
        if (exp[9] && exp[4] && exp_flush < CNT_MAX)   exp_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_init();
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL));
        reset_n = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        @(negedge clk);
        check("reset ctl", 32'(ctl_now()), 32'(C_RESET));
        check("reset stall_cycles", 32'(bus.o_stall_cycles), 32'd0);
        check("reset flush_count", 32'(bus.o_flush_count), 32'd0);
        #2 reset_n = 1'b1;
        #1;
        check("init ctl", 32'(ctl_now()), 32'(C_INIT));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t lu;
        reset_n = 1'b0;
        //          name              rs1 u1 rs2 u2 rd ld rdr req ack expected
        vecs.push_back(mk("run_normal",   1, 1,  2, 1, 3, 0, 0,  0,  0, C_NORMAL));
        vecs.push_back(mk("lu_rs2",       0, 0,  5, 1, 5, 1, 0,  0,  0, C_LDUSE));
        vecs.push_back(mk("after_lu",     0, 0,  5, 1, 5, 0, 0,  0,  0, C_NORMAL));
        vecs.push_back(mk("lu_rd0",       0, 1,  0, 1, 0, 1, 0,  0,  0, C_NORMAL));
        vecs.push_back(mk("lu_rs1_unused",7, 0,  1, 1, 7, 1, 0,  0,  0, C_NORMAL));
        vecs.push_back(mk("lu_rs1",       7, 1,  1, 0, 7, 1, 0,  0,  0, C_LDUSE));
        vecs.push_back(mk("no_load_match",3, 1,  3, 1, 3, 0, 0,  0,  0, C_NORMAL));
        vecs.push_back(mk("redir_over_lu",9, 1,  0, 0, 9, 1, 1,  0,  0, C_REDIR));
        vecs.push_back(mk("zero_wait_mem",0, 0,  0, 0, 0, 0, 0,  1,  1, C_NORMAL));
        vecs.push_back(mk("mem_wait1",    0, 0,  0, 0, 0, 0, 1,  1,  0, C_MEMSTL));
        vecs.push_back(mk("mem_wait2",    0, 0,  0, 0, 0, 0, 1,  1,  0, C_MEMSTL));
        vecs.push_back(mk("mem_wait3",    0, 0,  0, 0, 0, 0, 1,  1,  0, C_MEMSTL));
        vecs.push_back(mk("ack_redir",    0, 0,  0, 0, 0, 0, 1,  1,  1, C_REDIR));
        vecs.push_back(mk("post_ack",     0, 0,  0, 0, 0, 0, 0,  0,  0, C_NORMAL));
        vecs.push_back(mk("mem_over_lu",  4, 1,  0, 0, 4, 1, 0,  1,  0, C_MEMSTL));
        vecs.push_back(mk("ack_lu",       4, 1,  0, 0, 4, 1, 0,  1,  1, C_LDUSE));
        vecs.push_back(mk("post_ack_lu",  0, 0,  0, 0, 0, 0, 0,  0,  0, C_NORMAL));
        vecs.push_back(mk("to_wait1",     0, 0,  0, 0, 0, 0, 0,  1,  0, C_MEMSTL));
        vecs.push_back(mk("to_wait2",     0, 0,  0, 0, 0, 0, 0,  1,  0, C_MEMSTL));
        vecs.push_back(mk("to_wait3",     0, 0,  0, 0, 0, 0, 0,  1,  0, C_MEMSTL));
        vecs.push_back(mk("to_wait4",     0, 0,  0, 0, 0, 0, 0,  1,  0, C_MEMSTL));
        vecs.push_back(mk("err_ack",      0, 0,  0, 0, 0, 0, 1,  1,  1, C_ERR));
        vecs.push_back(mk("err_sticky",   0, 0,  0, 0, 0, 0, 0,  0,  0, C_ERR));
        vecs.push_back(mk("err_lu",       2, 1,  0, 0, 2, 1, 0,  0,  0, C_ERR));

        reset_and_init();
        foreach (vecs[i]) apply(vecs[i]);

        // Reset clears the sticky error and returns straight to INIT.
        reset_and_init();
        apply(mk("after_err_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL));

        // Reset asserted in the middle of a memory stall with a redirect pending.
        apply(mk("pre_reset_wait", 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEMSTL));
        drive(mk("held", 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEMSTL));
        #2 reset_n = 1'b0;
        #1;
        check("midstall_reset ctl", 32'(ctl_now()), 32'(C_RESET));
        check("midstall_reset stall_cycles", 32'(bus.o_stall_cycles), 32'd0);
        reset_and_init();
        apply(mk("no_pending_redir", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL));

        // Stall counter saturation under a continuous load-use hazard.
        lu = mk("sat_lu", 6, 1, 0, 0, 6, 1, 0, 0, 0, C_LDUSE);
        for (int i = 0; i < CNT_MAX + 5; i++) apply(lu);
        apply(mk("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL));
        check("sat_final stall_cycles", 32'(bus.o_stall_cycles), 32'(CNT_MAX));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
